// File: rtl/layer1_psum_collector.sv
// Layer-1 partial-sum collector.
// Accepts one 8-channel word of signed 16-bit partial sums per handshake and accumulates
// TAPS of them per output pixel. The first tap of a window also adds the per-channel bias.
// The finished sum is arithmetic-shifted by SHIFT, passed through ReLU and saturated to
// 0..32767, then presented as one packed 8-channel word. Pixels are counted per frame, and
// frame_done pulses for one cycle after the last pixel of a frame is taken downstream.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   in_valid   - psum word valid
//   in_ready   - collector can accept a psum word (high while accumulating)
//   in_data    - channel k (k=1..8) signed psum at [16k-1:16(k-1)]
//   bias_data  - per-channel signed bias, same packing, used on the first tap of a window
//   out_valid  - result word valid
//   out_ready  - downstream accepts the result
//   out_data   - per-channel 16-bit results after ReLU and saturation, same packing
//   frame_done - one-cycle pulse after the last pixel of a frame is accepted
module layer1_psum_collector #(
    parameter int unsigned TAPS       = 9,
    parameter int unsigned NUM_PIXELS = 1024,
    parameter int unsigned SHIFT      = 0,
    parameter int unsigned ACC_W      = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] bias_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         frame_done
);

    localparam int unsigned TapW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned PixW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [TapW-1:0] TapLast = TapW'(TAPS - 1);
    localparam logic [PixW-1:0] PixLast = PixW'(NUM_PIXELS - 1);
    localparam logic signed [ACC_W-1:0] SatMax = ACC_W'(32767);

    typedef enum logic [0:0] {StAcc, StOut} state_e;

    state_e                  state_q, state_d;
    logic [TapW-1:0]         tap_cnt_q, tap_cnt_d;
    logic [PixW-1:0]         pix_cnt_q, pix_cnt_d;
    logic signed [ACC_W-1:0] acc_q [8];
    logic signed [ACC_W-1:0] acc_d [8];
    logic [127:0]            out_data_q, out_data_d;
    logic                    frame_done_q, frame_done_d;

    logic in_hs;
    logic out_hs;
    logic last_tap;

    function automatic logic signed [ACC_W-1:0] sext16(input logic [15:0] v);
        return {{(ACC_W - 16){v[15]}}, v};
    endfunction

    // Rescale, clamp negatives to zero and saturate at the largest positive 16-bit value.
    function automatic logic [15:0] relu_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] t;
        t = a >>> SHIFT;
        if (t[ACC_W-1]) begin
            return 16'h0000;
        end else if (t > SatMax) begin
            return 16'h7fff;
        end else begin
            return t[15:0];
        end
    endfunction

    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;
    assign last_tap = in_hs && (tap_cnt_q == TapLast);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAcc;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAcc: if (last_tap) state_d = StOut;
            StOut: if (out_ready) state_d = StAcc;
            default: state_d = StAcc;
        endcase
    end

    // FSM outputs: input and output sides are never open in the same cycle
    always_comb begin
        in_ready  = (state_q == StAcc);
        out_valid = (state_q == StOut);
    end

    // Datapath next-state
    always_comb begin
        tap_cnt_d    = tap_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        out_data_d   = out_data_q;
        frame_done_d = out_hs && (pix_cnt_q == PixLast);

        if (in_hs) begin
            tap_cnt_d = last_tap ? '0 : tap_cnt_q + 1'b1;
        end
        if (out_hs) begin
            pix_cnt_d = (pix_cnt_q == PixLast) ? '0 : pix_cnt_q + 1'b1;
        end

        for (int k = 0; k < 8; k++) begin
            acc_d[k] = acc_q[k];
            if (in_hs) begin
                // First tap restarts from the bias so no residue survives between pixels.
                if (tap_cnt_q == '0) begin
                    acc_d[k] = sext16(bias_data[16*k +: 16]) + sext16(in_data[16*k +: 16]);
                end else begin
                    acc_d[k] = acc_q[k] + sext16(in_data[16*k +: 16]);
                end
            end
        end

        if (last_tap) begin
            for (int k = 0; k < 8; k++) begin
                out_data_d[16*k +: 16] = relu_sat(acc_d[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            tap_cnt_q    <= tap_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < 8; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/layer1_psum_collector.md
Name: layer1_psum_collector

Overview:
- Consumer end of the layer-1 processing-element array.
- Each cycle the PE array presents 8 signed 16-bit per-channel dot products, one per kernel tap.
- This block accepts those partial sums under a valid/ready handshake and accumulates TAPS of them per output pixel. It then adds a per-channel bias, applies an arithmetic shift, ReLU and saturation, and emits one packed 8-channel result word per pixel to the layer-1 output buffer.
- It counts pixels per frame and pulses frame_done after the last one.

Parameters:
- TAPS, 9, partial sums accumulated per output pixel (3x3 kernel).
- NUM_PIXELS, 1024, output pixels per frame (32x32).
- SHIFT, 0, arithmetic right shift applied after the bias add (fixed-point rescale), range 0..7.
- ACC_W, 22, accumulator width per channel.

Ports:
- clk, input, 1, clock; all state changes on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, psum word valid.
- in_ready, output, 1, block can accept a psum word.
- in_data, input, 128, channel k (k=1..8) signed psum at [16k-1:16(k-1)].
- bias_data, input, 128, per-channel signed 16-bit bias, same packing; sampled on the first-tap handshake.
- out_valid, output, 1, result word valid.
- out_ready, input, 1, downstream accepts result.
- out_data, output, 128, per-channel unsigned-after-ReLU 16-bit results, same packing.
- frame_done, output, 1, one-cycle pulse after the last pixel of a frame is accepted downstream.

Behaviour:
- Reset (rst=1 at an edge):
  - state=ACC, tap_cnt=0, pix_cnt=0, all accumulators=0.
  - out_valid=0, out_data=0, frame_done=0, in_ready=1 on the following cycle.
  - Reset mid-window or mid-output discards all partial state with no output.
- States: ACC, OUT.
- ACC:
  - in_ready=1, out_valid=0.
  - Input handshake = in_valid & in_ready.
  - On a handshake with tap_cnt==0: acc[k] = sext(in_data[k]) + sext(bias[k]), with bias_data latched that cycle.
  - On a handshake with tap_cnt>0: acc[k] += sext(in_data[k]).
  - tap_cnt increments per handshake.
  - The handshake with tap_cnt==TAPS-1 resets tap_cnt to 0, registers the result, and moves to OUT. out_valid=1 the next cycle, so latency is 1 cycle from the last tap handshake.
  - No handshake: state is held.
- Result per channel:
  - t = acc >>> SHIFT (arithmetic).
  - If t<0, result is 0.
  - Else if t>32767, result is 32767.
  - Else result = t[15:0].
  - Accumulation is full-precision in ACC_W bits. 9*(±32768) plus bias never overflows 22 bits.
- OUT:
  - in_ready=0, out_valid=1.
  - out_data is stable while out_valid=1 and out_ready=0 (backpressure held indefinitely).
  - On the handshake (out_valid & out_ready): state goes to ACC, out_valid=0 next cycle, pix_cnt increments.
- Frame boundary:
  - If the output handshake occurs with pix_cnt==NUM_PIXELS-1, pix_cnt wraps to 0 and frame_done=1 on the next cycle only.
  - The next frame starts with no extra idle cycle.
- Throughput:
  - Steady state with no stalls is TAPS+1 cycles per pixel.
  - Input is never accepted in the same cycle as an output handshake.
- in_valid toggling between taps is legal; gaps do not disturb tap_cnt.
- in_data and bias_data are don't-care when no input handshake occurs.

Test Plan:
- Basic sum: bias=0, SHIFT=0, 9 taps of every channel = 100, out_ready=1.
  - Required: out_valid high exactly 1 cycle after the 9th handshake.
  - Required: every channel = 900.
  - Required: in_ready=0 during that cycle.
- Bias, ReLU and saturation, 9 taps:
  - ch1: psum=-50, bias=+400. Required: ch1=0 (sum -50 clamps to 0).
  - ch2: psum=+5000, bias=0. Required: ch2=32767 (45000 saturates).
  - ch3: psum=+10, bias=-20. Required: ch3=70.
- Shift: SHIFT=2, taps=+7 on all channels, bias=+1. Required: 64>>>2 = 16 on every channel.
- Backpressure and gapped input:
  - Stimulus: random in_valid gaps; out_ready held low for 5 cycles after out_valid rises.
  - Required: out_data constant for those cycles and in_ready=0 throughout.
  - Required: the next window accumulates from a fresh base (no residue).
- Frame wrap: NUM_PIXELS=4, 4 full windows.
  - Required: frame_done pulses exactly once, 1 cycle after the 4th output handshake.
  - Required: pix_cnt restarts, and the 5th window produces a correct result.
- Reset mid-window: assert rst after 5 taps, release, then feed 9 taps of 1 with bias=0.
  - Required: result 9 on all channels.
  - Required: no out_valid between the reset and the 9th new tap.
